dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width in bits, legal range >= 1.
REQ-002 SHALL have parameter DEPTH, default 3: number of register stages, legal range >= 1.
REQ-003 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  advance enable; 0 = stall (all stages hold).
REQ-007 SHALL have port flush  input  1  synchronous clear of all valid bits.
REQ-008 SHALL have port d  input  WIDTH  input data.
REQ-009 SHALL have port d_valid  input  1  input data qualifier.
REQ-010 SHALL have port q  output  WIDTH  data of last stage.
REQ-011 SHALL have port q_valid  output  1  valid bit of last stage.
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of stages holding valid data.
REQ-013 SHALL have port parity_err  output  1  parity mismatch flag (see Configuration).

Function
REQ-014 Each stage SHALL hold one WIDTH-bit data register and one valid bit.
REQ-015 With en=1 and flush=0, on each rising edge, stage 0 SHALL load d/d_valid and stage k SHALL load stage k-1, for k = 1..DEPTH-1.
REQ-016 With en=0 and flush=0, all stages SHALL hold their data and valid bits.
REQ-017 Latency SHALL be exactly DEPTH enabled edges from d to q, with stalled edges not counted.
REQ-018 q and q_valid SHALL be driven directly from the last-stage registers, with no combinational path from d, d_valid or en.
REQ-019 With flush=1, on the next edge all valid bits SHALL clear, regardless of en.
REQ-020 flush SHALL take priority over en; d_valid presented in a flush cycle SHALL be dropped.
REQ-021 flush SHALL NOT modify data registers; data SHALL shift if en=1 and hold if en=0.
REQ-022 Data SHALL shift regardless of d_valid, so invalid bubbles propagate as ordinary stages.
REQ-023 occupancy SHALL be the registered-state popcount of valid bits, range 0..DEPTH, and SHALL never wrap.
REQ-024 With DEPTH=1, behaviour SHALL reduce to a single enabled register with valid bit.

Reset
REQ-025 While rst_n=0, all data stages SHALL equal RESET_VAL, all valid bits 0, q=RESET_VAL, q_valid=0, occupancy=0 and parity_err=0, independent of clk.
REQ-026 Reset assertion mid-stream SHALL discard in-flight data immediately, without waiting for a clock edge.
REQ-027 On the first rising edge after rst_n deasserts, normal operation per REQ-015..REQ-021 SHALL resume.

Configuration
REQ-028 Macro DFF_PIPE_PARITY_EN defined: each stage SHALL carry an extra even-parity bit, computed as XOR of d at stage 0 and shifted and held with its data.
REQ-029 With DFF_PIPE_PARITY_EN defined, parity_err SHALL equal q_valid AND (XOR(q) != stored parity), combinationally from the last-stage registers.
REQ-030 With DFF_PIPE_PARITY_EN defined, flush SHALL NOT alter parity bits, and reset SHALL load each parity bit with XOR(RESET_VAL).
REQ-031 Macro DFF_PIPE_PARITY_EN undefined: no parity storage SHALL exist, the parity_err port SHALL remain present, and it SHALL be tied to 0.

Verification (WIDTH=4, DEPTH=3, RESET_VAL=0 unless stated)
REQ-032 Reset: pulse rst_n low mid-stream while asynchronous to clk -> q=0, q_valid=0 and occupancy=0 immediately, without waiting for an edge.
REQ-033 Latency: en=1 throughout, d=3/d_valid=1 for one cycle, then d_valid=0 -> q=3 with q_valid=1 exactly 3 edges later, for one cycle; occupancy steps 1,1,1,0.
REQ-034 Stall: issue d=1,2,3 valid back-to-back, then en=0 for 4 cycles after the first edge -> outputs frozen; after en returns to 1, q emits 1,2,3 on consecutive edges; total latency = 3 + 4.
REQ-035 Flush: 3 valid words in flight and flush=1 with en=1 and d_valid=1 for one edge -> occupancy=0 and q_valid=0 next cycle; no word emerges afterwards.
REQ-036 Parity (macro defined): force the last-stage data register to 2 while its stored parity belongs to 3, with q_valid=1 -> parity_err=1; after release and a clean word 5 passes through -> parity_err=0.
REQ-037 Parity (macro undefined): the REQ-036 stimulus -> parity_err stays 0; repeat REQ-033 at WIDTH=8, DEPTH=1, RESET_VAL=8'hA5 -> reset q=8'hA5, latency 1.

Source files
------------

// File: rtl/dff_pipe.sv
// Purpose: DEPTH-stage enabled data/valid pipeline with flush, occupancy count and optional parity (DFF_PIPE_PARITY_EN).
// Latency: exactly DEPTH enabled edges from d to q; stalled edges are not counted.
// Backpressure: en=0 freezes every stage; flush clears valid bits only and wins over en.
module dff_pipe #(
  parameter int                 WIDTH     = 4,
  parameter int                 DEPTH     = 3,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         parity_err
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_q;

  // Data moves on en alone; flush only touches the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
    end else if (en) begin
      data_q[0] <= d;
      for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= d_valid;
      for (int k = 1; k < DEPTH; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(vld_q[k]);
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Parity travels with its data word, so it ignores flush just like the data does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= {DEPTH{^RESET_VAL}};
    end else if (en) begin
      par_q[0] <= ^d;
      for (int k = 1; k < DEPTH; k++) par_q[k] <= par_q[k-1];
    end
  end

  assign parity_err = vld_q[DEPTH-1] & ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: default 4x3 instance plus an 8-bit single-stage instance with RESET_VAL=8'hA5.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, flush, d_valid;
  logic [3:0] d;
  logic [3:0] q;
  logic       q_valid, parity_err;
  logic [1:0] occupancy;

  logic       en1, flush1, d_valid1;
  logic [7:0] d1, q1;
  logic       q_valid1, parity_err1;
  logic [0:0] occupancy1;

  logic [2:0][3:0] forced_val;
  logic            exp_perr;
  int              errors = 0;
  int              checks = 0;

  dff_pipe #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .occupancy(occupancy), .parity_err(parity_err)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .flush(flush1), .d(d1), .d_valid(d_valid1),
    .q(q1), .q_valid(q_valid1), .occupancy(occupancy1), .parity_err(parity_err1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; d = 4'd9; d_valid = 1'b1;
    en1 = 1'b1; flush1 = 1'b0; d1 = 8'h11; d_valid1 = 1'b1;
    #7;  // clock edge at 5 has passed while held in reset
    checks++; if (q !== 4'd0 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_q: q=%0d qv=%0b want 0/0", q, q_valid); end
    checks++; if (occupancy !== 2'd0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_occ: occ=%0d perr=%0b want 0/0", occupancy, parity_err); end
    checks++; if (q1 !== 8'hA5 || q_valid1 !== 1'b0) begin errors++; $display("FAIL reset_q1: q=%h qv=%0b want a5/0", q1, q_valid1); end
    d_valid = 1'b0; d_valid1 = 1'b0; d = 4'd0;
    #5 rst_n = 1'b1;
    tick();
    checks++; if (occupancy !== 2'd0 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: occ=%0d qv=%0b want 0/0", occupancy, q_valid); end
  endtask

  task automatic test_latency();
    logic [1:0] exp_occ [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic       exp_qv  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; d = 4'd3; d_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      d_valid = 1'b0; d = 4'd0;
      checks++; if (occupancy !== exp_occ[i] || q_valid !== exp_qv[i]) begin
        errors++; $display("FAIL latency_edge%0d: occ=%0d qv=%0b want %0d/%0b", i + 1, occupancy, q_valid, exp_occ[i], exp_qv[i]);
      end
      if (i == 2) begin
        checks++; if (q !== 4'd3) begin errors++; $display("FAIL latency_q: q=%0d want 3", q); end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_q [3] = '{4'd1, 4'd2, 4'd3};
    en = 1'b1; d = 4'd1; d_valid = 1'b1;
    tick();
    en = 1'b0; d = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (occupancy !== 2'd1 || q_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: occ=%0d qv=%0b want 1/0", i, occupancy, q_valid); end
    end
    en = 1'b1;
    tick();
    d = 4'd3;
    tick();
    d_valid = 1'b0; d = 4'd0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++; if (q_valid !== 1'b1 || q !== exp_q[i]) begin errors++; $display("FAIL stall_out%0d: q=%0d qv=%0b want %0d/1", i, q, q_valid, exp_q[i]); end
    end
    tick();
    checks++; if (q_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain: qv=%0b occ=%0d want 0/0", q_valid, occupancy); end
  endtask

  task automatic test_flush();
    en = 1'b1; d_valid = 1'b1;
    d = 4'd7; tick();
    d = 4'd8; tick();
    d = 4'd9; tick();
    checks++; if (occupancy !== 2'd3 || q !== 4'd7 || q_valid !== 1'b1) begin errors++; $display("FAIL flush_fill: occ=%0d q=%0d qv=%0b want 3/7/1", occupancy, q, q_valid); end
    flush = 1'b1; d = 4'd10;
    tick();
    flush = 1'b0; d_valid = 1'b0; d = 4'd0;
    checks++; if (occupancy !== 2'd0 || q_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: occ=%0d qv=%0b want 0/0", occupancy, q_valid); end
    checks++; if (q !== 4'd8) begin errors++; $display("FAIL flush_data_shift: q=%0d want 8", q); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emerge%0d: qv=%0b want 0", i, q_valid); end
    end
    // flush with en=0: valid clears, data holds
    d = 4'd4; d_valid = 1'b1; tick(); tick(); tick();
    en = 1'b0; flush = 1'b1; d_valid = 1'b0;
    tick();
    flush = 1'b0;
    checks++; if (q !== 4'd4 || q_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_stalled: q=%0d qv=%0b occ=%0d want 4/0/0", q, q_valid, occupancy); end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    en = 1'b1; d_valid = 1'b1; d = 4'd5;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0 || q_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL async_reset: q=%0d qv=%0b occ=%0d want 0/0/0", q, q_valid, occupancy); end
    #3 rst_n = 1'b1;
    d = 4'd6;
    tick();
    d_valid = 1'b0;
    checks++; if (occupancy !== 2'd1 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_resume: occ=%0d qv=%0b want 1/0", occupancy, q_valid); end
    tick(); tick();
    checks++; if (q !== 4'd6 || q_valid !== 1'b1) begin errors++; $display("FAIL reset_resume_q: q=%0d qv=%0b want 6/1", q, q_valid); end
    tick();
  endtask

  task automatic test_parity();
`ifdef DFF_PIPE_PARITY_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    en = 1'b1; d = 4'd3; d_valid = 1'b1;
    tick();
    d_valid = 1'b0; d = 4'd0;
    tick(); tick();
    en = 1'b0;
    checks++; if (q !== 4'd3 || q_valid !== 1'b1 || parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean3: q=%0d qv=%0b perr=%0b want 3/1/0", q, q_valid, parity_err); end
    forced_val = dut.data_q;
    forced_val[2] = 4'd2;
    force dut.data_q = forced_val;
    #1;
    checks++; if (parity_err !== exp_perr) begin errors++; $display("FAIL parity_forced: perr=%0b want %0b", parity_err, exp_perr); end
    release dut.data_q;
    en = 1'b1; d = 4'd5; d_valid = 1'b1;
    tick();
    d_valid = 1'b0; d = 4'd0;
    tick(); tick();
    checks++; if (q !== 4'd5 || q_valid !== 1'b1 || parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean5: q=%0d qv=%0b perr=%0b want 5/1/0", q, q_valid, parity_err); end
    tick();
  endtask

  task automatic test_depth1();
    en1 = 1'b1; d1 = 8'h3C; d_valid1 = 1'b1;
    tick();
    d_valid1 = 1'b0; d1 = 8'h00;
    checks++; if (q1 !== 8'h3C || q_valid1 !== 1'b1 || occupancy1 !== 1'b1) begin errors++; $display("FAIL depth1_lat: q=%h qv=%0b occ=%0d want 3c/1/1", q1, q_valid1, occupancy1); end
    tick();
    checks++; if (q_valid1 !== 1'b0 || occupancy1 !== 1'b0 || parity_err1 !== 1'b0) begin errors++; $display("FAIL depth1_drain: qv=%0b occ=%0d perr=%0b want 0/0/0", q_valid1, occupancy1, parity_err1); end
    en1 = 1'b0; d1 = 8'h77; d_valid1 = 1'b1;
    tick();
    checks++; if (q1 !== 8'h00 || q_valid1 !== 1'b0) begin errors++; $display("FAIL depth1_stall: q=%h qv=%0b want 00/0", q1, q_valid1); end
    d_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_async_reset();
    test_parity();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
